// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop processes
// two WIDTH-bit operands LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; result/carry hold the last completed value
// RUN   | one operand bit per edge through the shared full-adder slice
// DONE  | one-cycle done pulse; a start here chains the next op directly
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign s        = a_sh[0] ^ b_sh[0] ^ c;
    assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // The sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = s;
        end else begin : g_res_wn
            assign res_next = {s, result[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as a + ~b + 1: invert B and seed the carry with 1.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        c     <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    c      <= c_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    result <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        carry <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=4 (main), WIDTH=1 and WIDTH=8.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 0, sub4 = 0, busy4, done4, carry4;
    logic [3:0] a4 = 0, b4 = 0, result4;
    logic       start1 = 0, sub1 = 0, busy1, done1, carry1;
    logic [0:0] a1 = 0, b1 = 0, result1;
    logic       start8 = 0, sub8 = 0, busy8, done8, carry8;
    logic [7:0] a8 = 0, b8 = 0, result8;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .carry(carry4));
    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .carry(carry1));
    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .carry(carry8));

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] er;
        logic       ec;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            1: return busy1;
            8: return busy8;
            default: return busy4;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            1: return done1;
            8: return done8;
            default: return done4;
        endcase
    endfunction

    function automatic logic [7:0] get_result(input int w);
        case (w)
            1: return {7'd0, result1};
            8: return result8;
            default: return {4'd0, result4};
        endcase
    endfunction

    function automatic logic get_carry(input int w);
        case (w)
            1: return carry1;
            8: return carry8;
            default: return carry4;
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic s);
        case (w)
            1: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; sub1 = s; end
            8: begin start8 = st; a8 = av; b8 = bv; sub8 = s; end
            default: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; sub4 = s; end
        endcase
    endtask

    // One op: pulse start, scramble the inputs during RUN, expect done after w edges.
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic s, input logic [7:0] er, input logic ec,
                          input string name);
        logic busy_ok;
        drive(w, 1'b1, av, bv, s);
        tick();
        check({name, " busy_after_start"}, {31'd0, get_busy(w)}, 32'd1);
        drive(w, 1'b0, ~av, ~bv, ~s);
        busy_ok = 1'b1;
        for (int i = 1; i <= w; i++) begin
            tick();
            if (i < w && (!get_busy(w) || get_done(w))) busy_ok = 1'b0;
        end
        check({name, " busy_run"}, {31'd0, busy_ok}, 32'd1);
        check({name, " done_latency"}, {30'd0, get_done(w), get_busy(w)}, 32'b10);
        check({name, " result"}, {24'd0, get_result(w)}, {24'd0, er});
        check({name, " carry"}, {31'd0, get_carry(w)}, {31'd0, ec});
        tick();
        check({name, " done_one_cycle"}, {31'd0, get_done(w)}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0};
        vecs[1]  = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2]  = '{4'd5,  4'd3,  1'b1, 4'd2,  1'b1};
        vecs[3]  = '{4'd3,  4'd5,  1'b1, 4'd14, 1'b0};
        vecs[4]  = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[5]  = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1};
        vecs[6]  = '{4'd0,  4'd0,  1'b1, 4'd0,  1'b1};
        vecs[7]  = '{4'd0,  4'd1,  1'b1, 4'd15, 1'b0};
        vecs[8]  = '{4'd8,  4'd8,  1'b1, 4'd0,  1'b1};
        vecs[9]  = '{4'd7,  4'd9,  1'b0, 4'd0,  1'b1};
        vecs[10] = '{4'd9,  4'd2,  1'b1, 4'd7,  1'b1};
        vecs[11] = '{4'd2,  4'd9,  1'b1, 4'd9,  1'b0};

        // Reset state
        #2;
        for (int w = 1; w <= 8; w++) begin
            if (w == 1 || w == 4 || w == 8) begin
                check($sformatf("reset w%0d outputs", w),
                      {22'd0, get_busy(w), get_done(w), get_result(w)}, 32'd0);
                check($sformatf("reset w%0d carry", w), {31'd0, get_carry(w)}, 32'd0);
            end
        end
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 12; i++)
            run_op(4, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, vecs[i].sub,
                   {4'd0, vecs[i].er}, vecs[i].ec, $sformatf("vec%0d", i));

        // Start held high through RUN: only the first op computed, chained op from DONE
        start4 = 1; a4 = 4'd1; b4 = 4'd2; sub4 = 0;
        tick();
        a4 = 4'd10; b4 = 4'd4;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("b2b busy_run%0d", i), {30'd0, busy4, done4}, 32'b10);
        end
        tick();
        check("b2b first done", {31'd0, done4}, 32'd1);
        check("b2b first result", {27'd0, carry4, result4}, 32'd3);
        tick();
        check("b2b chained busy", {30'd0, busy4, done4}, 32'b10);
        start4 = 0; a4 = 4'd15; b4 = 4'd15; sub4 = 1;
        for (int i = 1; i <= 3; i++) tick();
        check("b2b second not yet done", {31'd0, done4}, 32'd0);
        tick();
        check("b2b second done period 5", {31'd0, done4}, 32'd1);
        check("b2b second result", {27'd0, carry4, result4}, 32'd14);
        tick();
        check("b2b idle after", {30'd0, busy4, done4}, 32'd0);

        // Reset in the second RUN cycle aborts the op
        start4 = 1; a4 = 4'd6; b4 = 4'd7; sub4 = 0;
        tick();
        start4 = 0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort outputs", {26'd0, busy4, done4, result4}, 32'd0);
        check("abort carry", {31'd0, carry4}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (done4 || busy4) saw_done = 1'b1;
            end
            check("abort no done", {31'd0, saw_done}, 32'd0);
        end
        run_op(4, 8'd6, 8'd7, 1'b0, 8'd13, 1'b0, "after_abort");

        // Exhaustive against golden arithmetic
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    logic [4:0] g;
                    g = (s == 1) ? 5'(x + ((~y) & 15) + 1) : 5'(x + y);
                    run_op(4, 8'(x), 8'(y), s[0], {4'd0, g[3:0]}, g[4],
                           $sformatf("ex s%0d a%0d b%0d", s, x, y));
                end

        // Width spot checks
        run_op(1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b1, "w1 1+1");
        run_op(1, 8'd1, 8'd1, 1'b1, 8'd0, 1'b1, "w1 1-1");
        run_op(1, 8'd0, 8'd1, 1'b1, 8'd1, 1'b0, "w1 0-1");
        run_op(8, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, "w8 200+100");
        run_op(8, 8'd100, 8'd200, 1'b1, 8'd156, 1'b0, "w8 100-200");
        run_op(8, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, "w8 255+1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
